wb_arb2: RTL

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_arb2.sv
// Two-master pipelined Wishbone arbiter: round-robin on ties, registered grant,
// outstanding-request throttling, and responses routed only to the bus owner.
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_wdata_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic            m0_stall_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_rdata_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic            m1_stall_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_wdata_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic            s_stall_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic [DW-1:0]   s_rdata_i
);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full, cnt_nz, accept, resp;

    assign full       = (cnt_q == CW'(MAX_OUT));
    assign cnt_nz     = (cnt_q != '0);
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = m0_we_i;
        s_addr_o   = m0_addr_i;
        s_wdata_o  = m0_wdata_i;
        s_sel_o    = m0_sel_i;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i & ~full;
                m0_stall_o = s_stall_i | full;
                m0_ack_o   = s_ack_i & cnt_nz;
                m0_err_o   = s_err_i & cnt_nz;
                if (!m0_cyc_i) state_d = IDLE;
            end
            OWN1: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i & ~full;
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_wdata_o  = m1_wdata_i;
                s_sel_o    = m1_sel_i;
                m1_stall_o = s_stall_i | full;
                m1_ack_o   = s_ack_i & cnt_nz;
                m1_err_o   = s_err_i & cnt_nz;
                if (!m1_cyc_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Responses with nothing outstanding are stray and never move the count.
        accept = s_stb_o & ~s_stall_i;
        resp   = (state_q != IDLE) & (s_ack_i | s_err_i) & cnt_nz;
        if (state_q != IDLE && state_d == IDLE) begin
            cnt_d = '0;
        end else if (accept && !resp) begin
            cnt_d = cnt_q + CW'(1);
        end else if (resp && !accept) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
